// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encodings, default widths
// and helpers that build the per-stage enable/flush bundle.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEFAULT = 5;

  localparam logic [1:0] S_RESET    = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } ctrl_t;

  function automatic ctrl_t ctrl_fill(input logic en, input logic flush);
    ctrl_t c;
    c.pc_en       = en;
    c.if_id_en    = en;
    c.if_id_flush = flush;
    c.id_ex_en    = en;
    c.id_ex_flush = flush;
    c.ex_mem_en   = en;
    c.mem_wb_en   = en;
    return c;
  endfunction

  // Normal-flow controls: a taken branch squashes IF/ID and ID/EX, which also
  // makes any load-use hazard on the squashed instruction irrelevant.
  function automatic ctrl_t run_ctrl(input logic branch, input logic load_use);
    ctrl_t c;
    if (branch) begin
      c = ctrl_fill(1'b1, 1'b1);
    end else if (load_use) begin
      c             = ctrl_fill(1'b1, 1'b0);
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end else begin
      c = ctrl_fill(1'b1, 1'b0);
    end
    return c;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_wait_timer.sv
// Memory-wait watchdog counter: clear, increment (clear+inc restarts at 1) and
// an expiry flag raised when the increment would reach MEM_TIMEOUT.
module pipe_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W:0] LIMIT = (TO_W + 1)'(MEM_TIMEOUT);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + {{TO_W{1'b0}}, 1'b1};

  always_comb begin
    cnt_d = cnt_q;
    if (clear && inc) begin
      cnt_d = TO_W'(1);
    end else if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_inc <= LIMIT)) begin
      cnt_d = cnt_inc[TO_W-1:0];
    end
  end

  // Expiry is judged on the count this cycle's wait brings us to.
  assign expired = inc && !clear && (cnt_inc >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage load enables / flush strobes for PC, IF_ID,
// ID_EX, EX_MEM, MEM_WB. Optional counters under macro PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEFAULT,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              halt_in,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              halted,
  output logic              mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  logic [1:0] state_q, state_d;
  logic       timeout_q, timeout_d;
  logic       timer_clear, timer_inc, timer_expired;
  logic       rs1_hit, rs2_hit, load_use;
  ctrl_t      ctrl;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

  pipe_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .inc    (timer_inc),
    .expired(timer_expired)
  );

  always_comb begin
    ctrl        = ctrl_fill(1'b0, 1'b0);
    state_d     = state_q;
    timeout_d   = timeout_q;
    timer_clear = 1'b0;
    timer_inc   = 1'b0;
    case (state_q)
      S_RESET: begin
        ctrl    = ctrl_fill(1'b0, 1'b1);
        state_d = S_RUN;
      end
      S_RUN: begin
        if (halt_in) begin
          state_d = S_HALT;
        end else if (mem_req && !mem_ready) begin
          timer_clear = 1'b1;
          timer_inc   = 1'b1;
          state_d     = S_MEM_WAIT;
        end else begin
          ctrl = run_ctrl(branch_taken, load_use);
        end
      end
      S_MEM_WAIT: begin
        // A completing access beats a watchdog expiry in the same cycle.
        if (!mem_ready) begin
          timer_inc = 1'b1;
          if (timer_expired) begin
            timeout_d = 1'b1;
            state_d   = S_HALT;
          end
        end else begin
          ctrl        = run_ctrl(branch_taken, load_use);
          timer_clear = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_en    = ctrl.id_ex_en;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;
  assign halted      = (state_q == S_HALT);
  assign mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;
  logic        stall_evt, flush_evt;

  // Only a branch raises a flush while the PC still advances.
  assign stall_evt = !ctrl.pc_en && ((state_q == S_RUN) || (state_q == S_MEM_WAIT));
  assign flush_evt = ctrl.if_id_flush && ctrl.pc_en;

  assign stall_d = stall_evt ? sat_inc32(stall_q) : stall_q;
  assign flush_d = flush_evt ? sat_inc32(flush_q) : flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule
